// File: rtl/rr_arb_pkg.sv
// Shared defaults and FSM state type for the grant dispatcher.
package rr_arb_pkg;

  localparam int DEF_INPUT_WIDTH = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational grant decoder: index of the set bit plus one-hot / multi-hot flags.
module onehot_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] i_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_one_hot,
  output logic             o_multi_hot
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] w_low_cleared;

  // Index is only meaningful when o_one_hot is set.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_grant[i]) begin
        o_index = i[IDX_W-1:0];
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only if 2+ bits were set.
  assign w_low_cleared = i_grant & (i_grant - ONE);
  assign o_multi_hot   = |w_low_cleared;
  assign o_one_hot     = (|i_grant) & ~o_multi_hot;

endmodule

// File: rtl/grant_dispatch.sv
// Captures the payload of the granted requester into a single-entry output
// stage with valid/ready handshake, one-cycle Ack and saturating grant counters.
module grant_dispatch
  import rr_arb_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [INPUT_WIDTH-1:0]                                  Grant,
  input  logic [INPUT_WIDTH*DATA_WIDTH-1:0]                       Data,
  output logic [INPUT_WIDTH-1:0]                                  Ack,
  output logic [DATA_WIDTH-1:0]                                   Out_data,
  output logic [((INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1)-1:0] Out_id,
  output logic                                                    Out_valid,
  input  logic                                                    Out_ready,
  output logic                                                    Err_multi,
  output logic [INPUT_WIDTH*CNT_WIDTH-1:0]                        Grant_cnt
);

  localparam int ID_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_capture;
  logic [ID_W-1:0]         w_idx;
  logic                    w_one_hot;
  logic                    w_multi_hot;
  logic [DATA_WIDTH-1:0]   w_slice [INPUT_WIDTH];

  logic [INPUT_WIDTH-1:0]  r_ack;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ID_W-1:0]         r_id;
  logic                    r_err;

  onehot_encoder #(
    .WIDTH (INPUT_WIDTH),
    .IDX_W (ID_W)
  ) u_encoder (
    .i_grant     (Grant),
    .o_index     (w_idx),
    .o_one_hot   (w_one_hot),
    .o_multi_hot (w_multi_hot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A grant is taken when the output stage is empty or being drained this cycle.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_one_hot) begin
          w_capture    = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (Out_ready) begin
          if (w_one_hot) begin
            w_capture = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= '0;
      r_data <= '0;
      r_id   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_ack <= w_capture ? Grant : '0;
      if (w_capture) begin
        r_data <= w_slice[w_idx];
        r_id   <= w_idx;
      end
      if (w_multi_hot) begin
        r_err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_WIDTH; gi++) begin : g_req
      logic [CNT_WIDTH-1:0] r_cnt;

      assign w_slice[gi] = Data[gi*DATA_WIDTH +: DATA_WIDTH];

      // Grant is one-hot whenever w_capture is set, so Grant[gi] selects the slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_capture && Grant[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end

      assign Grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
  endgenerate

  assign Ack       = r_ack;
  assign Out_data  = r_data;
  assign Out_id    = r_id;
  assign Out_valid = (r_state == SEND);
  assign Err_multi = r_err;

endmodule

// File: tb/tb_grant_dispatch.sv
// Randomized + directed bench for grant_dispatch against a transaction-level model.
module tb_grant_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  Grant = '0;
  logic [31:0] Data = '0;
  logic        Out_ready = 1'b0;

  logic [3:0]  Ack,  Ack2;
  logic [7:0]  Out_data, Out_data2;
  logic [1:0]  Out_id, Out_id2;
  logic        Out_valid, Out_valid2;
  logic        Err_multi, Err_multi2;
  logic [31:0] Grant_cnt;
  logic [7:0]  Grant_cnt2;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic [3:0] m_ack;
  logic       m_err;
  int         m_cnt  [4];
  int         m_cnt2 [4];

  always #5 clk = ~clk;

  grant_dispatch dut (
    .clk(clk), .rst_n(rst_n), .Grant(Grant), .Data(Data), .Ack(Ack),
    .Out_data(Out_data), .Out_id(Out_id), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Err_multi(Err_multi), .Grant_cnt(Grant_cnt)
  );

  grant_dispatch #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .Grant(Grant), .Data(Data), .Ack(Ack2),
    .Out_data(Out_data2), .Out_id(Out_id2), .Out_valid(Out_valid2),
    .Out_ready(Out_ready), .Err_multi(Err_multi2), .Grant_cnt(Grant_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = '0; m_ack = '0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_cnt2[i] = 0;
    end
  endtask

  // One clock of behaviour: the entry is free if empty or being drained now.
  task automatic model_update(input logic [3:0] g, input logic [31:0] d, input logic rdy);
    int  pop;
    int  idx;
    bit  cap;
    pop = $countones(g);
    if (pop > 1) m_err = 1'b1;
    cap = (pop == 1) && (!m_valid || rdy);
    m_ack = cap ? g : 4'b0000;
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      m_id    = 2'(idx);
      m_data  = d[idx*8 +: 8];
      m_valid = 1'b1;
      if (m_cnt[idx] < 255) m_cnt[idx]++;
      if (m_cnt2[idx] < 3) m_cnt2[idx]++;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_cnt;
    logic [7:0]  exp_cnt2;
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i*8 +: 8]  = 8'(m_cnt[i]);
      exp_cnt2[i*2 +: 2] = 2'(m_cnt2[i]);
    end
    check({tag, ".valid"}, 64'(Out_valid), 64'(m_valid));
    check({tag, ".ack"},   64'(Ack), 64'(m_ack));
    check({tag, ".err"},   64'(Err_multi), 64'(m_err));
    check({tag, ".cnt"},   64'(Grant_cnt), 64'(exp_cnt));
    check({tag, ".cnt2"},  64'(Grant_cnt2), 64'(exp_cnt2));
    check({tag, ".valid2"}, 64'(Out_valid2), 64'(m_valid));
    if (m_valid) begin
      check({tag, ".data"}, 64'(Out_data), 64'(m_data));
      check({tag, ".id"},   64'(Out_id), 64'(m_id));
    end
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [31:0] d, input logic rdy);
    Grant = g; Data = d; Out_ready = rdy;
    @(posedge clk);
    model_update(g, d, rdy);
    #1;
    compare_all(tag);
    $display("%s grant=%b ready=%b -> valid=%b id=%0d data=%h ack=%b err=%b",
             tag, g, rdy, Out_valid, Out_id, Out_data, Ack, Err_multi);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_valid"}, 64'(Out_valid), 64'd0);
    check({tag, ".rst_cnt"},   64'(Grant_cnt), 64'd0);
    check({tag, ".rst_ack"},   64'(Ack), 64'd0);
    check({tag, ".rst_data"},  64'(Out_data), 64'd0);
    check({tag, ".rst_err"},   64'(Err_multi), 64'd0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  held;
    logic [31:0] d;
    logic [3:0]  g;
    int          r;

    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    check("reset.id", 64'(Out_id), 64'd0);
    #10 rst_n = 1'b1;

    // Single grant to requester 2
    step("single", 4'b0100, 32'h11A5_2233, 1'b1);
    check("single.data", 64'(Out_data), 64'hA5);
    check("single.id",   64'(Out_id), 64'd2);
    check("single.ack",  64'(Ack), 64'b0100);
    check("single.cnt2", 64'(Grant_cnt[23:16]), 64'd1);
    step("single_drain", 4'b0000, 32'h0, 1'b1);
    check("single.ack_gone", 64'(Ack), 64'd0);

    // Backpressure: capture from requester 0 then hold
    step("bp_cap", 4'b0001, 32'hDEAD_BE5A, 1'b0);
    held = Out_data;
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 4'b0001, $urandom, 1'b0);
      check("bp.data_stable", 64'(Out_data), 64'(held));
      check("bp.no_ack", 64'(Ack), 64'd0);
      check("bp.cnt0", 64'(Grant_cnt[7:0]), 64'd1);
    end

    // Back-to-back captures with no bubble
    for (int i = 0; i < 4; i++) begin
      g = 4'b0001 << i;
      step("b2b", g, $urandom, 1'b1);
      check("b2b.valid", 64'(Out_valid), 64'd1);
      check("b2b.id", 64'(Out_id), 64'(i));
      check("b2b.ack", 64'(Ack), 64'(g));
    end
    step("b2b_drain", 4'b0000, 32'h0, 1'b1);
    check("b2b.idle", 64'(Out_valid), 64'd0);

    // Multi-hot grant from IDLE
    step("multi", 4'b0011, $urandom, 1'b1);
    check("multi.ack", 64'(Ack), 64'd0);
    check("multi.valid", 64'(Out_valid), 64'd0);
    check("multi.err", 64'(Err_multi), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step("multi_after", 4'b0001 << (i % 4), $urandom, 1'b1);
    end
    check("multi.sticky", 64'(Err_multi), 64'd1);

    // Saturation of the narrow counter
    async_reset("sat");
    for (int i = 0; i < 5; i++) step("sat", 4'b1000, $urandom, 1'b1);
    check("sat.cnt3_w2", 64'(Grant_cnt2[7:6]), 64'd3);
    check("sat.cnt3_w8", 64'(Grant_cnt[31:24]), 64'd5);

    // Reset while an entry is waiting for the consumer
    step("midsend", 4'b0010, $urandom, 1'b0);
    check("midsend.valid", 64'(Out_valid), 64'd1);
    async_reset("midsend");
    step("post_rst", 4'b0000, 32'h0, 1'b1);
    check("post_rst.ack", 64'(Ack), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 4) g = 4'b0000;
      else if (r < 19) g = 4'b0001 << $urandom_range(0, 3);
      else begin
        do g = 4'($urandom); while ($countones(g) < 2);
      end
      d = $urandom;
      step("rand", g, d, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
